// File: rtl/l1_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : l1_cache_assoc
// Brief    : N-way set-associative write-back/write-allocate L1 cache with
//            true-LRU replacement and saturating hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module l1_cache_assoc #(
    parameter int ADDR_W   = 30,
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 2,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [31:0]       proc_wdata,
    output logic              proc_stall,
    output logic [31:0]       proc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [127:0]      mem_wdata,
    input  logic [127:0]      mem_rdata,
    input  logic              mem_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int AGE_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    localparam logic [AGE_W-1:0] c_AGE_MAX = AGE_W'(NUM_WAYS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WB    = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_ALLOC = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;

    logic [NUM_WAYS-1:0] r_valid [NUM_SETS];
    logic [NUM_WAYS-1:0] r_dirty [NUM_SETS];
    logic [AGE_W-1:0]    r_age   [NUM_SETS][NUM_WAYS];
    logic [TAG_W-1:0]    r_tag   [NUM_SETS][NUM_WAYS];
    logic [127:0]        r_data  [NUM_SETS][NUM_WAYS];

    logic [AGE_W-1:0]    r_victim;
    logic [ADDR_W-3:0]   r_wb_addr;
    logic [127:0]        r_wb_data;
    logic [CNT_W-1:0]    r_hit_cnt;
    logic [CNT_W-1:0]    r_miss_cnt;

    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_idx;
    logic [1:0]          w_off;
    logic                w_req;
    logic                w_hit;
    logic [AGE_W-1:0]    w_hit_way;
    logic [AGE_W-1:0]    w_victim;
    logic                w_hit_acc;
    logic                w_wr_hit;
    logic                w_miss;
    logic                w_fill;
    logic                w_touch_en;
    logic [AGE_W-1:0]    w_touch_way;
    logic [127:0]        w_hit_line;

    assign w_tag = proc_addr[ADDR_W-1 -: TAG_W];
    assign w_idx = proc_addr[2 +: IDX_W];
    assign w_off = proc_addr[1:0];
    assign w_req = proc_read | proc_write;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = AGE_W'(w);
            end
        end
    end

    // Lowest-index invalid way wins over the LRU way, so scan it last.
    always_comb begin
        w_victim = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_age[w_idx][w] == c_AGE_MAX) w_victim = AGE_W'(w);
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) w_victim = AGE_W'(w);
        end
    end

    assign w_hit_acc   = (r_state == c_IDLE) & w_req & w_hit;
    assign w_wr_hit    = w_hit_acc & proc_write;
    assign w_miss      = (r_state == c_IDLE) & w_req & ~w_hit;
    assign w_fill      = (r_state == c_ALLOC) & mem_ready;
    assign w_touch_en  = w_hit_acc | w_fill;
    assign w_touch_way = w_fill ? r_victim : w_hit_way;

    assign w_hit_line  = r_data[w_idx][w_hit_way];
    assign proc_rdata  = w_hit_line[{w_off, 5'b0} +: 32];
    assign mem_wdata   = r_wb_data;
    assign hit_cnt     = r_hit_cnt;
    assign miss_cnt    = r_miss_cnt;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) r_state <= c_IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_miss) begin
                    w_state_next = (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                                   ? c_WB : c_ALLOC;
                end
            end
            c_WB:    if (mem_ready) w_state_next = c_WAIT;
            c_WAIT:  w_state_next = c_ALLOC;
            c_ALLOC: if (mem_ready) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        proc_stall = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[ADDR_W-1:2];
        case (r_state)
            c_IDLE:  proc_stall = w_req & ~w_hit;
            c_WB: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = r_wb_addr;
            end
            c_WAIT:  proc_stall = 1'b1;
            c_ALLOC: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
            end
            default: proc_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) r_age[s][w] <= AGE_W'(w);
            end
            r_victim   <= '0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_miss) begin
                r_victim  <= w_victim;
                r_wb_addr <= {r_tag[w_idx][w_victim], w_idx};
                r_wb_data <= r_data[w_idx][w_victim];
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
            end
            if (w_hit_acc && (r_hit_cnt != '1)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            if (w_wr_hit) r_dirty[w_idx][w_hit_way] <= 1'b1;
            if (w_fill) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
            end
            // Younger ways age by one; the touched way becomes most recent.
            if (w_touch_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (AGE_W'(w) == w_touch_way)
                        r_age[w_idx][w] <= '0;
                    else if (r_age[w_idx][w] < r_age[w_idx][w_touch_way])
                        r_age[w_idx][w] <= r_age[w_idx][w] + AGE_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[w_idx][r_victim] <= mem_rdata;
            r_tag[w_idx][r_victim]  <= w_tag;
        end
        if (w_wr_hit) r_data[w_idx][w_hit_way][{w_off, 5'b0} +: 32] <= proc_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_l1_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_l1_cache_assoc
// Brief    : Scoreboard bench for l1_cache_assoc against an LRU-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l1_cache_assoc;
    localparam int ADDR_W   = 16;
    localparam int NUM_SETS = 8;
    localparam int NUM_WAYS = 4;
    localparam int CNT_W    = 5;
    localparam int IDX_W    = 3;
    localparam int TAG_W    = ADDR_W - 2 - IDX_W;
    localparam int CMAX     = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              proc_reset;
    logic              proc_read;
    logic              proc_write;
    logic [ADDR_W-1:0] proc_addr;
    logic [31:0]       proc_wdata;
    logic              proc_stall;
    logic [31:0]       proc_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-3:0] mem_addr;
    logic [127:0]      mem_wdata;
    logic [127:0]      mem_rdata;
    logic              mem_ready;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    l1_cache_assoc #(
        .ADDR_W(ADDR_W), .NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .proc_reset(proc_reset), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_stall(proc_stall),
        .proc_rdata(proc_rdata), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_wr;
        bit          hit;
        logic [31:0] rdata;
        int          hcnt;
        int          mcnt;
        int          issue;
    } sb_t;

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-3:0] addr;
        logic [127:0]      data;
    } mt_t;

    sb_t sb_q[$];
    mt_t mem_q[$];

    // Reference: per-set tag list ordered most- to least-recently used.
    logic [TAG_W-1:0] m_tag   [NUM_SETS][NUM_WAYS];
    bit               m_dirty [NUM_SETS][NUM_WAYS];
    int               m_cnt   [NUM_SETS];
    int               m_hits;
    int               m_misses;
    logic [31:0]      gold [int];
    logic [127:0]     mem  [int];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic logic [31:0] gold_word(input int a);
        return gold.exists(a) ? gold[a] : init_word(a);
    endfunction

    function automatic logic [127:0] gold_line(input int la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = gold_word(la * 4 + k);
        return l;
    endfunction

    function automatic logic [127:0] mem_line(input int la);
        logic [127:0] l;
        if (mem.exists(la)) return mem[la];
        for (int k = 0; k < 4; k++) l[32*k +: 32] = init_word(la * 4 + k);
        return l;
    endfunction

    function automatic logic [ADDR_W-1:0] mk(input int t, input int s, input int o);
        return ADDR_W'((t << (IDX_W + 2)) + (s << 2) + o);
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NUM_SETS; s++) m_cnt[s] = 0;
        m_hits   = 0;
        m_misses = 0;
        gold.delete();
        foreach (mem[k]) for (int j = 0; j < 4; j++) gold[k * 4 + j] = mem[k][32*j +: 32];
    endtask

    task automatic model_step(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                              output sb_t e);
        int               s, pos, wa;
        logic [TAG_W-1:0] t, st;
        bit               sd;
        mt_t              mt;
        s   = int'(a[2 +: IDX_W]);
        t   = a[ADDR_W-1 -: TAG_W];
        wa  = int'(a);
        pos = -1;
        for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
        e.hit = (pos >= 0);
        if (pos < 0) begin
            m_misses++;
            if (m_cnt[s] == NUM_WAYS) begin
                if (m_dirty[s][NUM_WAYS-1]) begin
                    mt.is_wr = 1'b1;
                    mt.addr  = {m_tag[s][NUM_WAYS-1], IDX_W'(s)};
                    mt.data  = gold_line(int'(mt.addr));
                    mem_q.push_back(mt);
                end
                m_cnt[s]--;
            end
            mt.is_wr = 1'b0;
            mt.addr  = a[ADDR_W-1:2];
            mt.data  = '0;
            mem_q.push_back(mt);
            for (int i = m_cnt[s]; i > 0; i--) begin
                m_tag[s][i]   = m_tag[s][i-1];
                m_dirty[s][i] = m_dirty[s][i-1];
            end
            m_tag[s][0]   = t;
            m_dirty[s][0] = 1'b0;
            m_cnt[s]++;
        end else begin
            st = m_tag[s][pos];
            sd = m_dirty[s][pos];
            for (int i = pos; i > 0; i--) begin
                m_tag[s][i]   = m_tag[s][i-1];
                m_dirty[s][i] = m_dirty[s][i-1];
            end
            m_tag[s][0]   = st;
            m_dirty[s][0] = sd;
        end
        if (wr) begin
            m_dirty[s][0] = 1'b1;
            gold[wa]      = d;
        end
        e.is_wr = wr;
        e.rdata = gold_word(wa);
        e.hcnt  = sat(m_hits);
        e.mcnt  = sat(m_misses);
        e.issue = 0;
        m_hits++;
    endtask

    // Called aligned 1 time unit after a rising edge; returns aligned the same way.
    task automatic do_req(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        sb_t e;
        bit  done;
        model_step(wr, a, d, e);
        proc_write = wr;
        proc_read  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        proc_addr  = a;
        proc_wdata = d;
        e.issue    = cyc;
        sb_q.push_back(e);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!proc_stall) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL req_timeout addr=%h got=stalled exp=complete", a);
        end
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    // Memory/L2 responder with random latency.
    initial begin
        bit busy;
        int cnt;
        busy      = 1'b0;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ready = 1'b0;
            if (proc_reset) begin
                busy = 1'b0;
            end else if (busy) begin
                if (cnt == 0) begin
                    if (mem_write) mem[int'(mem_addr)] = mem_wdata;
                    if (mem_read)  mem_rdata = mem_line(int'(mem_addr));
                    mem_ready = 1'b1;
                    busy      = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (mem_read || mem_write) begin
                busy = 1'b1;
                cnt  = $urandom_range(0, 3);
            end
        end
    end

    // Monitor: processor completions and memory transactions.
    initial begin
        bit  pmr, pmw, gap, rdchk;
        sb_t e;
        mt_t m;
        pmr = 0; pmw = 0; gap = 0; rdchk = 0;
        forever begin
            @(negedge clk);
            if (proc_reset) begin
                pmr = 0; pmw = 0; gap = 0; rdchk = 0;
            end else begin
                if ((proc_read || proc_write) && !proc_stall) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion got=addr_%h exp=none", proc_addr);
                    end else begin
                        e = sb_q.pop_front();
                        chk("hit_no_stall", 128'(cyc == e.issue), 128'(e.hit));
                        if (!e.is_wr) chk("rdata", 128'(proc_rdata), 128'(e.rdata));
                        chk("hit_cnt", 128'(hit_cnt), 128'(e.hcnt));
                        chk("miss_cnt", 128'(miss_cnt), 128'(e.mcnt));
                    end
                end
                if (mem_read || mem_write) chk("mem_overlap", 128'(mem_read & mem_write), 128'(0));
                if (gap)   chk("wait_gap", 128'({mem_read, mem_write}), 128'(0));
                if (rdchk) chk("alloc_after_wait", 128'(mem_read), 128'(1));
                rdchk = gap;
                gap   = mem_write && mem_ready;
                if ((mem_write && !pmw) || (mem_read && !pmr)) begin
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_mem_req got=addr_%h exp=none", mem_addr);
                    end else begin
                        m = mem_q.pop_front();
                        chk("mem_kind_is_wb", 128'(mem_write), 128'(m.is_wr));
                        chk("mem_addr", 128'(mem_addr), 128'(m.addr));
                        if (m.is_wr) chk("wb_data", mem_wdata, m.data);
                    end
                end
                pmr = mem_read;
                pmw = mem_write;
            end
        end
    end

    initial begin
        sb_t              e;
        bit               seen;
        logic [ADDR_W-1:0] ra;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        proc_reset = 1'b0;
        chk("rst_stall", 128'(proc_stall), 128'(0));
        chk("rst_mem_rw", 128'({mem_read, mem_write}), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        chk("rst_counters", 128'({hit_cnt, miss_cnt}), 128'(0));

        // First fill of word 0x10, then write/read-back in the same line.
        do_req(1'b0, 16'h0010, 32'h0);
        chk("first_hit_cnt", 128'(hit_cnt), 128'(1));
        chk("first_miss_cnt", 128'(miss_cnt), 128'(1));
        do_req(1'b1, 16'h0011, 32'hA5A5A5A5);
        do_req(1'b0, 16'h0011, 32'h0);

        // LRU: five tags into set 0, re-touch the first; the second goes.
        for (int t = 1; t <= 4; t++) do_req(1'b0, mk(t, 0, t - 1), 32'h0);
        do_req(1'b0, mk(1, 0, 0), 32'h0);
        do_req(1'b0, mk(5, 0, 0), 32'h0);
        do_req(1'b0, mk(1, 0, 1), 32'h0);
        do_req(1'b0, mk(2, 0, 0), 32'h0);
        do_req(1'b0, mk(3, 0, 0), 32'h0);

        // Dirty victim write-back and round trip through memory.
        do_req(1'b1, mk(1, 1, 2), 32'hDEADBEEF);
        for (int t = 2; t <= 5; t++) do_req(1'b0, mk(t, 1, 0), 32'h0);
        do_req(1'b0, mk(1, 1, 2), 32'h0);

        // Reset while a refill is outstanding.
        ra = mk(9, 5, 1);
        model_step(1'b0, ra, 32'h0, e);
        proc_read = 1'b1;
        proc_addr = ra;
        e.issue   = cyc;
        sb_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (mem_read) seen = 1'b1;
        end
        chk("reset_test_alloc_seen", 128'(seen), 128'(1));
        #2;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        #1;
        chk("midrst_stall", 128'(proc_stall), 128'(0));
        chk("midrst_mem_rw", 128'({mem_read, mem_write}), 128'(0));
        chk("midrst_mem_wdata", mem_wdata, 128'(0));
        chk("midrst_counters", 128'({hit_cnt, miss_cnt}), 128'(0));
        sb_q.delete();
        mem_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        proc_reset = 1'b0;
        do_req(1'b0, ra, 32'h0);
        chk("post_rst_miss_cnt", 128'(miss_cnt), 128'(1));

        // Randomised traffic over a few crowded sets; counters saturate.
        for (int n = 0; n < 250; n++) begin
            do_req(1'($urandom_range(0, 9) < 4),
                   mk($urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 3)),
                   $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        @(posedge clk);
        #1;
        chk("final_hit_cnt", 128'(hit_cnt), 128'(sat(m_hits)));
        chk("final_miss_cnt", 128'(miss_cnt), 128'(sat(m_misses)));
        chk("sb_drained", 128'(sb_q.size()), 128'(0));
        chk("mem_q_drained", 128'(mem_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
